// File: rtl/mem_req_ctrl_if.sv
// Data-cache request/response bundle between the MEM-stage controller
// (master) and the data cache (slave).
interface mem_req_ctrl_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// MEM-stage memory request controller: sequences one cache access per load/store,
// stalls the pipeline meanwhile, and tracks the LL/SC link register.
module mem_req_ctrl (
  input  logic           clk,
  input  logic           nRst,
  input  logic           MemRead,
  input  logic           MemWrite,
  input  logic           ll,
  input  logic           sc,
  input  logic           halt_in,
  input  logic [31:0]    addr,
  input  logic [31:0]    store_data,
  input  logic           snoop_inv,
  input  logic [31:0]    snoop_addr,
  output logic [31:0]    load_data,
  output logic           pipe_wen,
  output logic           halted,
  mem_req_ctrl_if.master dcif
);

  typedef logic [31:0] word_t;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] COMPLETE = 2'd2;
  localparam logic [1:0] HALTED   = 2'd3;

  logic [1:0]  state_q, state_d;
  word_t       addr_q, addr_d;
  word_t       store_q, store_d;
  logic        op_write_q, op_write_d;
  logic        op_sc_q, op_sc_d;
  logic        op_ll_q, op_ll_d;
  word_t       load_data_q, load_data_d;
  logic        link_valid_q, link_valid_d;
  logic [29:0] link_addr_q, link_addr_d;

  logic snoop_hit;
  logic sc_link_ok;
  logic snoop_hits_new_link;
  logic unused_snoop_lsbs;

  assign unused_snoop_lsbs = &{1'b0, snoop_addr[1:0]};

  // A snoop on the linked word in the same cycle as the SC check must win,
  // so the SC sees the link as already gone.
  assign snoop_hit           = snoop_inv && (snoop_addr[31:2] == link_addr_q);
  assign sc_link_ok          = link_valid_q && !snoop_hit && (link_addr_q == addr[31:2]);
  assign snoop_hits_new_link = snoop_inv && (snoop_addr[31:2] == addr_q[31:2]);

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    store_d        = store_q;
    op_write_d     = op_write_q;
    op_sc_d        = op_sc_q;
    op_ll_d        = op_ll_q;
    load_data_d    = load_data_q;
    link_valid_d   = link_valid_q;
    link_addr_d    = link_addr_q;
    pipe_wen       = 1'b0;
    dcif.dmemREN   = 1'b0;
    dcif.dmemWEN   = 1'b0;
    dcif.dmemaddr  = '0;
    dcif.dmemstore = '0;

    if (snoop_hit) begin
      link_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (MemWrite) begin
          addr_d     = addr;
          store_d    = store_data;
          op_write_d = 1'b1;
          op_sc_d    = sc;
          op_ll_d    = 1'b0;
          if (sc && !sc_link_ok) begin
            load_data_d = '0;
            state_d     = COMPLETE;
          end else begin
            state_d = ACCESS;
          end
        end else if (MemRead) begin
          addr_d     = addr;
          store_d    = store_data;
          op_write_d = 1'b0;
          op_sc_d    = 1'b0;
          op_ll_d    = ll;
          state_d    = ACCESS;
        end else if (halt_in) begin
          state_d = HALTED;
        end else begin
          pipe_wen = 1'b1;
        end
      end

      // An SC that reached this state is committed; later snoops only drop the link.
      ACCESS: begin
        dcif.dmemREN   = !op_write_q;
        dcif.dmemWEN   = op_write_q;
        dcif.dmemaddr  = addr_q;
        dcif.dmemstore = store_q;
        if (dcif.dhit) begin
          state_d = COMPLETE;
          if (op_write_q) begin
            if (op_sc_q) begin
              load_data_d  = 32'd1;
              link_valid_d = 1'b0;
            end else if (link_addr_q == addr_q[31:2]) begin
              link_valid_d = 1'b0;
            end
          end else begin
            load_data_d = dcif.dmemload;
            if (op_ll_q) begin
              link_valid_d = !snoop_hits_new_link;
              link_addr_d  = addr_q[31:2];
            end
          end
        end
      end

      COMPLETE: begin
        pipe_wen = 1'b1;
        state_d  = IDLE;
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      store_q      <= '0;
      op_write_q   <= 1'b0;
      op_sc_q      <= 1'b0;
      op_ll_q      <= 1'b0;
      load_data_q  <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      op_write_q   <= op_write_d;
      op_sc_q      <= op_sc_d;
      op_ll_q      <= op_ll_d;
      load_data_q  <= load_data_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  assign load_data = load_data_q;
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: per-cycle vector table for loads, stores
// and LL/SC, plus hand sequences for halt and reset during an access.
module tb_mem_req_ctrl;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        ll;
    logic        sc;
    logic        halt;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        dhit;
    logic [31:0] dload;
    logic        snp;
    logic [31:0] saddr;
    logic        e_ren;
    logic        e_wen;
    logic        e_pipe;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [31:0] e_ld;
  } vec_t;

  logic        clk;
  logic        nRst;
  logic        MemRead;
  logic        MemWrite;
  logic        ll;
  logic        sc;
  logic        halt_in;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        snoop_inv;
  logic [31:0] snoop_addr;
  logic [31:0] load_data;
  logic        pipe_wen;
  logic        halted;

  int tests_run;
  int tests_failed;

  vec_t vecs[$];

  mem_req_ctrl_if dcif ();

  mem_req_ctrl dut (
    .clk        (clk),
    .nRst       (nRst),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ll         (ll),
    .sc         (sc),
    .halt_in    (halt_in),
    .addr       (addr),
    .store_data (store_data),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .load_data  (load_data),
    .pipe_wen   (pipe_wen),
    .halted     (halted),
    .dcif       (dcif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input logic rd, input logic wr, input logic l, input logic s, input logic h,
    input logic [31:0] a, input logic [31:0] sd, input logic dh, input logic [31:0] dl,
    input logic sn, input logic [31:0] sa,
    input logic er, input logic ew, input logic ep,
    input logic [31:0] ea, input logic [31:0] es, input logic [31:0] eld);
    vec_t v;
    v.rd = rd; v.wr = wr; v.ll = l; v.sc = s; v.halt = h;
    v.addr = a; v.sdata = sd; v.dhit = dh; v.dload = dl;
    v.snp = sn; v.saddr = sa;
    v.e_ren = er; v.e_wen = ew; v.e_pipe = ep;
    v.e_addr = ea; v.e_store = es; v.e_ld = eld;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    MemRead       = v.rd;
    MemWrite      = v.wr;
    ll            = v.ll;
    sc            = v.sc;
    halt_in       = v.halt;
    addr          = v.addr;
    store_data    = v.sdata;
    dcif.dhit     = v.dhit;
    dcif.dmemload = v.dload;
    snoop_inv     = v.snp;
    snoop_addr    = v.saddr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    vec_t z;
    z = mkVec(0,0,0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0);
    applyStimulus(z);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //          rd wr ll sc h  addr  sdata dh dload        sn saddr  ren wen pipe eaddr estore eld
    // plain load, dhit after two ACCESS cycles
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mkVec(1,0,0,0,0, 32'h40, 32'h0, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mkVec(1,0,0,0,0, 32'h40, 32'h0, 0,32'h0,        0,32'h0,   1,0,0, 32'h40, 32'h0, 32'h0));
    vecs.push_back(mkVec(1,0,0,0,0, 32'h40, 32'h0, 1,32'hDEADBEEF, 0,32'h0,   1,0,0, 32'h40, 32'h0, 32'h0));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'hDEADBEEF));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'hDEADBEEF));
    // LL 0x80 then successful SC 0x80, then a repeat SC fails
    vecs.push_back(mkVec(1,0,1,0,0, 32'h80, 32'h0, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'hDEADBEEF));
    vecs.push_back(mkVec(1,0,1,0,0, 32'h80, 32'h0, 1,32'h1234,     0,32'h0,   1,0,0, 32'h80, 32'h0, 32'hDEADBEEF));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h1234));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h80, 32'h5, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h1234));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h80, 32'h5, 0,32'h0,        0,32'h0,   0,1,0, 32'h80, 32'h5, 32'h1234));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h80, 32'h5, 1,32'h0,        0,32'h0,   0,1,0, 32'h80, 32'h5, 32'h1234));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h1));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h80, 32'h7, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h1));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h0));
    // LL 0x80, snoop 0x84 (no effect), snoop 0x80 (clears), SC fails
    vecs.push_back(mkVec(1,0,1,0,0, 32'h80, 32'h0, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mkVec(1,0,1,0,0, 32'h80, 32'h0, 1,32'h55,       0,32'h0,   1,0,0, 32'h80, 32'h0, 32'h0));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        1,32'h84,  0,0,1, 32'h0,  32'h0, 32'h55));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        1,32'h80,  0,0,1, 32'h0,  32'h0, 32'h55));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h80, 32'h9, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h55));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h0));
    // LL 0x80, snoop 0x84 only, SC succeeds even with a snoop on 0x80 mid-ACCESS
    vecs.push_back(mkVec(1,0,1,0,0, 32'h80, 32'h0, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mkVec(1,0,1,0,0, 32'h80, 32'h0, 1,32'h66,       0,32'h0,   1,0,0, 32'h80, 32'h0, 32'h0));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        1,32'h84,  0,0,1, 32'h0,  32'h0, 32'h66));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h80, 32'hA, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h66));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h80, 32'hA, 0,32'h0,        1,32'h80,  0,1,0, 32'h80, 32'hA, 32'h66));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h80, 32'hA, 1,32'h0,        0,32'h0,   0,1,0, 32'h80, 32'hA, 32'h66));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h1));
    // LL 0x100, SC 0x100 with snoop 0x100 in the same IDLE cycle fails
    vecs.push_back(mkVec(1,0,1,0,0, 32'h100,32'h0, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h1));
    vecs.push_back(mkVec(1,0,1,0,0, 32'h100,32'h0, 1,32'h77,       0,32'h0,   1,0,0, 32'h100,32'h0, 32'h1));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h77));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h100,32'h3, 0,32'h0,        1,32'h100, 0,0,0, 32'h0,  32'h0, 32'h77));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h0));
    // LL 0x200, read+write together (store wins) to 0x200 kills the link
    vecs.push_back(mkVec(1,0,1,0,0, 32'h200,32'h0, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mkVec(1,0,1,0,0, 32'h200,32'h0, 1,32'h88,       0,32'h0,   1,0,0, 32'h200,32'h0, 32'h0));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h88));
    vecs.push_back(mkVec(1,1,0,0,0, 32'h200,32'h99,0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h88));
    vecs.push_back(mkVec(1,1,0,0,0, 32'h200,32'h99,1,32'hFFFF,     0,32'h0,   0,1,0, 32'h200,32'h99,32'h88));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h88));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h200,32'h1, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h88));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h0));
    // LL 0x300 with a snoop on 0x300 in the dhit cycle never links
    vecs.push_back(mkVec(1,0,1,0,0, 32'h300,32'h0, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'h0));
    vecs.push_back(mkVec(1,0,1,0,0, 32'h300,32'h0, 1,32'hAB,       1,32'h300, 1,0,0, 32'h300,32'h0, 32'h0));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'hAB));
    vecs.push_back(mkVec(0,1,0,1,0, 32'h300,32'h2, 0,32'h0,        0,32'h0,   0,0,0, 32'h0,  32'h0, 32'hAB));
    vecs.push_back(mkVec(0,0,0,0,0, 32'h0,  32'h0, 0,32'h0,        0,32'h0,   0,0,1, 32'h0,  32'h0, 32'h0));

    // reset state
    nRst = 1'b0;
    idleInputs();
    #7;
    checkOutput("reset ren",       {31'd0, dcif.dmemREN}, 32'd0);
    checkOutput("reset wen",       {31'd0, dcif.dmemWEN}, 32'd0);
    checkOutput("reset dmemaddr",  dcif.dmemaddr,         32'd0);
    checkOutput("reset dmemstore", dcif.dmemstore,        32'd0);
    checkOutput("reset pipe_wen",  {31'd0, pipe_wen},     32'd1);
    checkOutput("reset load_data", load_data,             32'd0);
    checkOutput("reset halted",    {31'd0, halted},       32'd0);
    @(negedge clk);
    nRst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d ren", i),       {31'd0, dcif.dmemREN}, {31'd0, vecs[i].e_ren});
      checkOutput($sformatf("v%0d wen", i),       {31'd0, dcif.dmemWEN}, {31'd0, vecs[i].e_wen});
      checkOutput($sformatf("v%0d pipe_wen", i),  {31'd0, pipe_wen},     {31'd0, vecs[i].e_pipe});
      checkOutput($sformatf("v%0d dmemaddr", i),  dcif.dmemaddr,         vecs[i].e_addr);
      checkOutput($sformatf("v%0d dmemstore", i), dcif.dmemstore,        vecs[i].e_store);
      checkOutput($sformatf("v%0d load_data", i), load_data,             vecs[i].e_ld);
    end

    // halt: stalls, stays halted ignoring ops, reset releases it
    @(negedge clk);
    idleInputs();
    halt_in = 1'b1;
    #1;
    checkOutput("halt entry pipe_wen", {31'd0, pipe_wen}, 32'd0);
    @(negedge clk);
    halt_in = 1'b0;
    MemRead = 1'b1;
    addr    = 32'h40;
    for (int c = 0; c < 12; c++) begin
      #1;
      checkOutput($sformatf("halted c%0d", c),   {31'd0, halted},       32'd1);
      checkOutput($sformatf("halt pipe c%0d", c), {31'd0, pipe_wen},    32'd0);
      checkOutput($sformatf("halt ren c%0d", c),  {31'd0, dcif.dmemREN}, 32'd0);
      @(negedge clk);
    end
    MemRead = 1'b0;
    nRst    = 1'b0;
    #1;
    checkOutput("halt async clear", {31'd0, halted}, 32'd0);
    @(negedge clk);
    nRst = 1'b1;
    #1;
    checkOutput("post-halt pipe_wen", {31'd0, pipe_wen}, 32'd1);
    checkOutput("post-halt halted",   {31'd0, halted},   32'd0);

    // reset in the middle of a store access drops the request at once
    @(negedge clk);
    MemWrite   = 1'b1;
    addr       = 32'h44;
    store_data = 32'h1111;
    @(negedge clk);
    #1;
    checkOutput("mid store wen",  {31'd0, dcif.dmemWEN}, 32'd1);
    checkOutput("mid store addr", dcif.dmemaddr,         32'h44);
    dcif.dhit = 1'b1;
    nRst      = 1'b0;
    #1;
    checkOutput("rst wen drop",   {31'd0, dcif.dmemWEN}, 32'd0);
    checkOutput("rst addr drop",  dcif.dmemaddr,         32'd0);
    checkOutput("rst store drop", dcif.dmemstore,        32'd0);
    @(negedge clk);
    idleInputs();
    nRst = 1'b1;
    #1;
    checkOutput("rst idle pipe_wen", {31'd0, pipe_wen},     32'd1);
    checkOutput("rst idle wen",      {31'd0, dcif.dmemWEN}, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rst no complete", {31'd0, pipe_wen}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
